// File: rtl/expr_sweep_misr_pkg.sv
// expr_sweep_pkg: shared constants, FSM state type and MISR helper functions
// for the expr_sweep_misr expression-semantics hammer.
package expr_sweep_pkg;

   localparam int NUM_LANES = 8;
   // Widest signature / lane bus the helper functions can handle.
   localparam int MAX_SIG_W = 64;
   localparam int MAX_BUS_W = 512;
   localparam int SIG_IDX_W = $clog2(MAX_SIG_W);
   localparam int BUS_IDX_W = $clog2(MAX_BUS_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One Galois step over the low sig_w bits: shift left, fold in poly on MSB.
   function automatic logic [MAX_SIG_W-1:0] misr_step(
      input logic [MAX_SIG_W-1:0] sig,
      input logic [MAX_SIG_W-1:0] poly,
      input int                   sig_w
   );
      logic [MAX_SIG_W-1:0] mask;
      logic [MAX_SIG_W-1:0] nxt;
      mask = {MAX_SIG_W{1'b1}} >> (MAX_SIG_W - sig_w);
      nxt  = (sig << 1) & mask;
      if (sig[SIG_IDX_W'(sig_w - 1)]) begin
         nxt = nxt ^ (poly & mask);
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

   // XOR of all sig_w-bit chunks of the low bus_w bits (upper chunk zero-padded).
   function automatic logic [MAX_SIG_W-1:0] lane_fold(
      input logic [MAX_BUS_W-1:0] bits,
      input int                   bus_w,
      input int                   sig_w
   );
      logic [MAX_SIG_W-1:0] acc;
      acc = {MAX_SIG_W{1'b0}};
      for (int i = 0; i < MAX_BUS_W; i++) begin
         if (i < bus_w) begin
            acc[SIG_IDX_W'(i % sig_w)] = acc[SIG_IDX_W'(i % sig_w)] ^ bits[BUS_IDX_W'(i)];
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/expr_sweep_misr_if.sv
// Control/observation bundle of expr_sweep_misr: start/hold in, status,
// signature and lane bank out.
interface expr_sweep_misr_if #(
   parameter int SIG_W = 32,
   parameter int WY    = 8
);
   import expr_sweep_pkg::*;

   logic                    start;
   logic                    hold;
   logic                    busy;
   logic                    done;
   logic [SIG_W-1:0]        signature;
   logic [NUM_LANES*WY-1:0] lane_q;

   modport master (output start, hold, input busy, done, signature, lane_q);
   modport slave  (input start, hold, output busy, done, signature, lane_q);
endinterface

// File: rtl/expr_sweep_misr_lane_bank.sv
// expr_lane_bank: combinational bank of eight width-extension / signedness
// expressions over signed a and unsigned b, each a WY-bit lane.
// Optional power lane enabled by macro EXPR_SWEEP_POW_EN.
// Operands are widened explicitly to what the WY-bit assignment context
// would produce (sign-extension for signed contexts, zero-extension for
// unsigned ones), so every lane is an unambiguous WY-bit expression.
// Assumes WY > 2*WA and WY > WB.
module expr_lane_bank
   import expr_sweep_pkg::*;
#(
   parameter int WA = 3,
   parameter int WB = 4,
   parameter int WY = 8
) (
   input  logic signed [WA-1:0]       a,
   input  logic        [WB-1:0]       b,
   output logic [NUM_LANES*WY-1:0]    lanes
);

   logic signed [WY-1:0] a_sx_s;
   logic signed [WY-1:0] b_sx_s;
   logic        [WY-1:0] a_zx_s;
   logic        [WY-1:0] b_zx_s;
   logic        [WY-1:0] l0_s, l1_s, l2_s, l3_s, l4_s, l5_s, l6_s, l7_s;

   assign a_sx_s = {{(WY-WA){a[WA-1]}}, a};
   assign a_zx_s = {{(WY-WA){1'b0}}, a};
   assign b_sx_s = {{(WY-WB){b[WB-1]}}, b};
   assign b_zx_s = {{(WY-WB){1'b0}}, b};

   // Evaluate the eight lanes; divide by zero and the disabled power lane give 0.
   always_comb begin
      l0_s = {{(WY-2*WA){1'b0}}, a, a};               // concat: unsigned, zero-ext
      l1_s = {{(WY-1){1'b0}}, (a_zx_s == b_zx_s)};    // mixed compare: unsigned
      l2_s = a_sx_s << b;                             // a sign-ext, b unsigned amount
      l3_s = a_sx_s >>> b;                            // arithmetic shift
      l4_s = a_sx_s + b_sx_s;                         // fully signed add
      l5_s = a_zx_s * b_zx_s;                         // mixed multiply: unsigned
      if (b == {WB{1'b0}}) begin
         l6_s = {WY{1'b0}};
      end else begin
         l6_s = a_zx_s / b_zx_s;                      // mixed divide: unsigned
      end
`ifdef EXPR_SWEEP_POW_EN
      l7_s = a_sx_s ** b;                             // signed base, unsigned exponent
`else
      l7_s = {WY{1'b0}};
`endif
      lanes = {l7_s, l6_s, l5_s, l4_s, l3_s, l2_s, l1_s, l0_s};
   end

endmodule

// File: rtl/expr_sweep_misr.sv
// expr_sweep_misr: sweeps every {b,a} vector through expr_lane_bank and
// compresses the lanes into a MISR signature. Three-stage pipeline:
// S1 operands, S2 lanes (lane_q), S3 MISR. Macro EXPR_SWEEP_POW_EN
// enables the power lane inside expr_lane_bank.
module expr_sweep_misr
   import expr_sweep_pkg::*;
#(
   parameter int                   WA    = 3,
   parameter int                   WB    = 4,
   parameter int                   WY    = 8,
   parameter int                   SIG_W = 32,
   parameter logic [MAX_SIG_W-1:0] POLY  = 64'h0000_0000_04C1_1DB7,
   parameter logic [SIG_W-1:0]     SEED  = {SIG_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   expr_sweep_misr_if.slave bus
);

   localparam int CW     = WA + WB;
   localparam int LANE_W = NUM_LANES * WY;
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

   state_t                state_r, state_d;
   logic [CW-1:0]         cnt_r, cnt_d;
   logic                  drain_r, drain_d;
   logic                  busy_r, busy_d;
   logic                  done_r, done_d;
   logic                  issue_s, clear_s;
   logic                  s1_v_r;
   logic signed [WA-1:0]  s1_a_r;
   logic [WB-1:0]         s1_b_r;
   logic                  s2_v_r;
   logic [LANE_W-1:0]     lanes_s;
   logic [LANE_W-1:0]     lane_q_r;
   logic [SIG_W-1:0]      sig_r, sig_d;

   // Sequencer next state, vector counter and registered status decode.
   always_comb begin
      state_d = state_r;
      cnt_d   = cnt_r;
      drain_d = drain_r;
      issue_s = 1'b0;
      clear_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               cnt_d   = {CW{1'b0}};
               clear_s = 1'b1;
            end else begin
               state_d = state_r;
            end
         end
         ST_RUN: begin
            issue_s = 1'b1;
            cnt_d   = cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
               state_d = ST_DRAIN;
               drain_d = 1'b0;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_r) begin
               state_d = ST_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_r == ST_RUN) || (state_r == ST_DRAIN);
      done_d = (state_r == ST_DONE) && !clear_s;
   end

   // Sequencer state and status registers; hold freezes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         drain_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (!bus.hold) begin
         state_r <= state_d;
         cnt_r   <= cnt_d;
         drain_r <= drain_d;
         busy_r  <= busy_d;
         done_r  <= done_d;
      end
   end

   expr_lane_bank #(.WA(WA), .WB(WB), .WY(WY)) u_lane_bank (
      .a     (s1_a_r),
      .b     (s1_b_r),
      .lanes (lanes_s)
   );

   // S1 operand capture and S2 lane capture; hold freezes the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_r   <= 1'b0;
         s1_a_r   <= {WA{1'b0}};
         s1_b_r   <= {WB{1'b0}};
         s2_v_r   <= 1'b0;
         lane_q_r <= {LANE_W{1'b0}};
      end else if (!bus.hold) begin
         s1_v_r   <= issue_s;
         s1_a_r   <= cnt_r[WA-1:0];
         s1_b_r   <= cnt_r[CW-1:WA];
         s2_v_r   <= s1_v_r;
         lane_q_r <= lanes_s;
      end
   end

   // S3 signature update: reseed on accepted start, absorb valid lane banks.
   always_comb begin
      sig_d = sig_r;
      if (clear_s) begin
         sig_d = SEED;
      end else if (s2_v_r) begin
         sig_d = SIG_W'(misr_step(MAX_SIG_W'(sig_r), POLY, SIG_W))
               ^ SIG_W'(lane_fold(MAX_BUS_W'(lane_q_r), LANE_W, SIG_W));
      end else begin
         sig_d = sig_r;
      end
   end

   // MISR register; hold freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_r <= SEED;
      end else if (!bus.hold) begin
         sig_r <= sig_d;
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.signature = sig_r;
   assign bus.lane_q    = lane_q_r;

endmodule

// File: tb/tb_expr_sweep_misr.sv
// Directed bench for expr_sweep_misr: a WA=3/WB=4 instance for lane
// semantics and a WA=1/WB=1 instance for timing, hold, restart and reset.
module tb_expr_sweep_misr;

   localparam int SIG_W = 32;
   localparam int WY    = 8;
   localparam logic [31:0] SEED = 32'hFFFF_FFFF;
   localparam logic [7:0] L7_POW =
`ifdef EXPR_SWEEP_POW_EN
      8'h01;
`else
      8'h00;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] gold_a, gold_b;

   always #5 clk = ~clk;

   expr_sweep_misr_if #(.SIG_W(SIG_W), .WY(WY)) bus_a ();
   expr_sweep_misr_if #(.SIG_W(SIG_W), .WY(WY)) bus_b ();

   expr_sweep_misr #(.WA(3), .WB(4), .WY(WY), .SIG_W(SIG_W)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   expr_sweep_misr #(.WA(1), .WB(1), .WY(WY), .SIG_W(SIG_W)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   // Reference lanes from plain integer arithmetic on the decoded operands.
   function automatic logic [63:0] model_lanes(input int wa, input int wb, input int k);
      int au, asg, bu, bsg, p;
      logic [63:0] r;
      au  = k % (1 << wa);
      asg = (au >= (1 << (wa - 1))) ? au - (1 << wa) : au;
      bu  = k >> wa;
      bsg = (bu >= (1 << (wb - 1))) ? bu - (1 << wb) : bu;
      p   = 1;
      for (int j = 0; j < bu; j++) p = (p * asg) & 255;
      r[7:0]   = 8'((au << wa) | au);
      r[15:8]  = (au == bu) ? 8'h01 : 8'h00;
      r[23:16] = 8'(asg << bu);
      r[31:24] = 8'(asg >>> bu);
      r[39:32] = 8'(asg + bsg);
      r[47:40] = 8'(au * bu);
      r[55:48] = (bu == 0) ? 8'h00 : 8'(au / bu);
`ifdef EXPR_SWEEP_POW_EN
      r[63:56] = 8'(p);
`else
      r[63:56] = 8'h00;
`endif
      return r;
   endfunction

   function automatic logic [31:0] model_sig(input int wa, input int wb);
      logic [31:0] s;
      logic [63:0] l;
      s = SEED;
      for (int k = 0; k < (1 << (wa + wb)); k++) begin
         l = model_lanes(wa, wb, k);
         s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0000_0000) ^ l[31:0] ^ l[63:32];
      end
      return s;
   endfunction

   // Run one sweep on dut_b with optional hold window and a second start pulse.
   task automatic sweep_b(input int hold_from, input int hold_len, input int restart_at,
                          output int busy_cnt, output int done_at, output logic [31:0] sig_out);
      logic [31:0] sig_hold;
      busy_cnt = 0;
      done_at  = -1;
      sig_hold = 32'h0;
      @(negedge clk); bus_b.start = 1'b1; bus_b.hold = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus_b.signature !== SEED || bus_b.done !== 1'b0) begin
         failures++;
         $display("FAIL accept_b sig=%h done=%b exp sig=%h done=0", bus_b.signature, bus_b.done, SEED);
      end
      for (int m = 1; m <= 40 && done_at < 0; m++) begin
         @(negedge clk);
         bus_b.hold  = (m > hold_from) && (m <= hold_from + hold_len);
         bus_b.start = (m == restart_at);
         if (m == hold_from + 1) sig_hold = bus_b.signature;
         @(posedge clk); #1;
         if (bus_b.busy === 1'b1) busy_cnt++;
         if (bus_b.done === 1'b1) done_at = m;
         if (hold_len > 0 && m == hold_from + hold_len) begin
            checks++;
            if (bus_b.signature !== sig_hold) begin
               failures++;
               $display("FAIL hold_freeze sig=%h exp=%h", bus_b.signature, sig_hold);
            end
         end
      end
      @(negedge clk); bus_b.hold = 1'b0; bus_b.start = 1'b0;
      sig_out = bus_b.signature;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_a.start = 1'b0; bus_a.hold = 1'b0;
      bus_b.start = 1'b0; bus_b.hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_a.signature !== SEED || bus_a.lane_q !== 64'h0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_a sig=%h lane=%h busy=%b done=%b", bus_a.signature, bus_a.lane_q, bus_a.busy, bus_a.done);
      end
      checks++;
      if (bus_b.signature !== SEED || bus_b.lane_q !== 64'h0 || bus_b.busy !== 1'b0 || bus_b.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_b sig=%h lane=%h busy=%b done=%b", bus_b.signature, bus_b.lane_q, bus_b.busy, bus_b.done);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   // Full dut_a sweep: every lane bank against the model, two directed vectors.
   task automatic test_lanes();
      logic [63:0] exp_k4, exp_k23, want;
      int done_at, busy_cnt;
      exp_k4  = {L7_POW, 56'h00_00_FC_FC_FC_00_24};
      exp_k23 = {L7_POW, 56'h03_0E_01_FF_FC_00_3F};
      done_at = -1; busy_cnt = 0;
      @(negedge clk); bus_a.start = 1'b1;
      @(posedge clk); #1; bus_a.start = 1'b0;
      for (int m = 1; m <= 200 && done_at < 0; m++) begin
         @(posedge clk); #1;
         if (bus_a.busy === 1'b1) busy_cnt++;
         if (bus_a.done === 1'b1) done_at = m;
         if (m >= 2 && m <= 129) begin
            want = model_lanes(3, 4, m - 2);
            checks++;
            if (bus_a.lane_q !== want) begin
               failures++;
               $display("FAIL lane_sweep vec=%0d got=%h exp=%h", m - 2, bus_a.lane_q, want);
            end
         end
         if (m == 6 || m == 25) begin
            want = (m == 6) ? exp_k4 : exp_k23;
            for (int i = 0; i < 8; i++) begin
               checks++;
               if (bus_a.lane_q[i*8 +: 8] !== want[i*8 +: 8]) begin
                  failures++;
                  $display("FAIL lane_directed vec=%0d L%0d got=%h exp=%h", m - 2, i, bus_a.lane_q[i*8 +: 8], want[i*8 +: 8]);
               end
            end
         end
      end
      checks++;
      if (done_at != 131 || busy_cnt != 130) begin
         failures++;
         $display("FAIL timing_a done_at=%0d busy=%0d exp done_at=131 busy=130", done_at, busy_cnt);
      end
      checks++;
      if (bus_a.signature !== gold_a) begin
         failures++;
         $display("FAIL sig_a got=%h exp=%h", bus_a.signature, gold_a);
      end
   endtask

   task automatic test_timing();
      int bc, da; logic [31:0] s;
      sweep_b(0, 0, 0, bc, da, s);
      checks++;
      if (bc != 6 || da != 7) begin
         failures++;
         $display("FAIL timing_b busy=%0d done_at=%0d exp busy=6 done_at=7", bc, da);
      end
      checks++;
      if (s !== gold_b) begin
         failures++;
         $display("FAIL sig_b got=%h exp=%h", s, gold_b);
      end
   endtask

   task automatic test_hold();
      int bc, da; logic [31:0] s;
      sweep_b(1, 5, 0, bc, da, s);
      checks++;
      if (da != 12) begin
         failures++;
         $display("FAIL hold_delay done_at=%0d exp=12", da);
      end
      checks++;
      if (s !== gold_b) begin
         failures++;
         $display("FAIL hold_sig got=%h exp=%h", s, gold_b);
      end
      // start together with hold in DONE is not accepted
      @(negedge clk); bus_b.hold = 1'b1; bus_b.start = 1'b1;
      @(negedge clk); bus_b.hold = 1'b0; bus_b.start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin
         failures++;
         $display("FAIL hold_start done=%b busy=%b exp done=1 busy=0", bus_b.done, bus_b.busy);
      end
   endtask

   task automatic test_start_in_run();
      int bc, da; logic [31:0] s;
      sweep_b(0, 0, 2, bc, da, s);
      checks++;
      if (da != 7 || s !== gold_b) begin
         failures++;
         $display("FAIL start_in_run done_at=%0d sig=%h exp done_at=7 sig=%h", da, s, gold_b);
      end
   endtask

   task automatic test_reset_drain();
      int bc, da; logic [31:0] s;
      @(negedge clk); bus_b.start = 1'b1;
      @(posedge clk); #1; bus_b.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus_b.busy !== 1'b1) begin
         failures++;
         $display("FAIL drain_busy busy=%b exp=1", bus_b.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus_b.signature !== SEED || bus_b.busy !== 1'b0 || bus_b.done !== 1'b0 || bus_b.lane_q !== 64'h0) begin
         failures++;
         $display("FAIL reset_drain sig=%h busy=%b done=%b lane=%h", bus_b.signature, bus_b.busy, bus_b.done, bus_b.lane_q);
      end
      @(negedge clk); rst_n = 1'b1;
      sweep_b(0, 0, 0, bc, da, s);
      checks++;
      if (da != 7 || s !== gold_b) begin
         failures++;
         $display("FAIL rerun_after_reset done_at=%0d sig=%h exp done_at=7 sig=%h", da, s, gold_b);
      end
   endtask

   // Restart directly from DONE; done must drop right after the accepting edge.
   task automatic test_back_to_back();
      int bc, da; logic [31:0] s;
      checks++;
      if (bus_b.done !== 1'b1) begin
         failures++;
         $display("FAIL done_before_restart done=%b exp=1", bus_b.done);
      end
      sweep_b(0, 0, 0, bc, da, s);
      checks++;
      if (da != 7 || s !== gold_b) begin
         failures++;
         $display("FAIL back_to_back done_at=%0d sig=%h exp done_at=7 sig=%h", da, s, gold_b);
      end
   endtask

   initial begin
      gold_a = model_sig(3, 4);
      gold_b = model_sig(1, 1);
      test_reset();
      test_lanes();
      test_timing();
      test_hold();
      test_start_in_run();
      test_reset_drain();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
